// File: rtl/mem_access_unit_if.sv
// Bundles the MEM-stage request/response handshake and the DataMemory port of mem_access_unit.
// The slave view is the unit; the master view is its environment (MEM stage plus memory).
interface mem_access_unit_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [31:0]           req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_misaligned;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_misaligned, mem_addr, mem_we, mem_re, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned, mem_addr, mem_we, mem_re, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-only DataMemory: sub-word loads are extracted and extended,
// sub-word stores are merged by read-modify-write, misaligned requests are rejected untouched.
module mem_access_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input logic             clk,
  input logic             rst,
  mem_access_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [1:0]            r_lane;
  logic [15:0]           r_wdata;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_mis;

  logic                  w_accept;
  logic                  w_mis;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic [DATA_WIDTH-1:0] w_merged;
  logic                  w_unused;

  assign w_accept = bus.req_valid && (r_state == IDLE) && !rst;
  assign w_mis    = (bus.req_size == 2'b11) ||
                    ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                    ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  // Address bits above the word index are deliberately ignored (accesses wrap).
  assign w_unused = ^bus.req_addr[31:ADDR_WIDTH+2];

  always_comb begin
    w_byte = bus.mem_rdata[{r_lane, 3'b000} +: 8];
    w_half = r_lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (r_size)
      2'b00:   w_load_data = r_unsigned ? {{(DATA_WIDTH-8){1'b0}}, w_byte}
                                        : {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      2'b01:   w_load_data = r_unsigned ? {{(DATA_WIDTH-16){1'b0}}, w_half}
                                        : {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      default: w_load_data = bus.mem_rdata;
    endcase
    w_merged = bus.mem_rdata;
    if (r_size == 2'b00) w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
    else                 w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata;
  end

  always_comb begin
    w_next             = r_state;
    bus.req_ready      = 1'b0;
    bus.mem_re         = 1'b0;
    bus.mem_we         = 1'b0;
    bus.rsp_valid      = 1'b0;
    bus.rsp_rdata      = r_rsp_rdata;
    bus.rsp_misaligned = r_rsp_mis;
    bus.mem_addr       = r_addr;
    bus.mem_wdata      = r_mem_wdata;
    case (r_state)
      IDLE: begin
        bus.req_ready = !rst;
        if (w_accept) begin
          if (w_mis)                        w_next = RESP;
          else if (!bus.req_we)             w_next = LOAD;
          else if (bus.req_size == 2'b10)   w_next = WRITE;
          else                              w_next = RMW_RD;
        end
      end
      LOAD: begin
        bus.mem_re = !rst;
        w_next     = RESP;
      end
      RMW_RD: begin
        bus.mem_re = !rst;
        w_next     = WRITE;
      end
      WRITE: begin
        bus.mem_we = !rst;
        w_next     = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        w_next        = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_size      <= '0;
      r_unsigned  <= 1'b0;
      r_lane      <= '0;
      r_wdata     <= '0;
      r_addr      <= '0;
      r_mem_wdata <= '0;
      r_rsp_rdata <= '0;
      r_rsp_mis   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we       <= bus.req_we;
            r_size     <= bus.req_size;
            r_unsigned <= bus.req_unsigned;
            r_lane     <= bus.req_addr[1:0];
            r_wdata    <= bus.req_wdata[15:0];
            r_addr     <= bus.req_addr[ADDR_WIDTH+1:2];
            if (w_mis) begin
              r_rsp_rdata <= '0;
              r_rsp_mis   <= 1'b1;
            end else if (bus.req_we && (bus.req_size == 2'b10)) begin
              r_mem_wdata <= bus.req_wdata;
            end
          end
        end
        LOAD: begin
          r_rsp_rdata <= w_load_data;
          r_rsp_mis   <= 1'b0;
        end
        RMW_RD: r_mem_wdata <= w_merged;
        WRITE: begin
          r_rsp_rdata <= '0;
          r_rsp_mis   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural word-only DataMemory
// (combinational read, write committed on the falling edge).
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] ram [16];
  assign bus.mem_rdata = ram[bus.mem_addr];
  always @(negedge clk) if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    int          exp_lat;
    int          exp_re;
    int          exp_we;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          lat;
    int          re;
    int          we;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    exp_t e;
    int   lat = 0;
    int   re_n = 0;
    int   we_n = 0;
    e = '{v.exp_rdata, v.exp_mis, v.exp_lat, v.exp_re, v.exp_we};
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = v.we;
    bus.req_size     = v.size;
    bus.req_unsigned = v.uns;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    sb.push_back(e);
    check($sformatf("v%0d req_ready", idx), 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.mem_re) re_n++;
      if (bus.mem_we) we_n++;
      if (bus.mem_re && bus.mem_we) check($sformatf("v%0d re_we_excl", idx), 32'd1, 32'd0);
      if (bus.rsp_valid) begin
        lat = c;
        break;
      end
    end
    e = sb.pop_front();
    if (lat == 0) begin
      check($sformatf("v%0d rsp_timeout", idx), 32'd0, 32'd1);
    end else begin
      check($sformatf("v%0d rsp_rdata", idx), bus.rsp_rdata, e.rdata);
      check($sformatf("v%0d rsp_misaligned", idx), 32'(bus.rsp_misaligned), 32'(e.mis));
      check($sformatf("v%0d latency", idx), 32'(lat), 32'(e.lat));
      check($sformatf("v%0d mem_re_cycles", idx), 32'(re_n), 32'(e.re));
      check($sformatf("v%0d mem_we_cycles", idx), 32'(we_n), 32'(e.we));
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = '0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;

    //        we    size   uns   addr          wdata         rdata         mis  lat re we
    vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 2, 0, 1});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0048, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 2, 1, 0});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h0000_0009, 32'h1234_565A, 32'h0000_0000, 1'b0, 3, 1, 1});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0000_000B, 32'h0000_0000, 32'hFFFF_FFDE, 1'b0, 2, 1, 0});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h0000_000B, 32'h0000_0000, 32'h0000_00DE, 1'b0, 2, 1, 0});
    vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h0000_000A, 32'h0000_0000, 32'hFFFF_DEAD, 1'b0, 2, 1, 0});
    vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h0000_0008, 32'h0000_0000, 32'h0000_5AEF, 1'b0, 2, 1, 0});
    vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h0000_0003, 32'h0000_0000, 32'h0000_0000, 1'b1, 1, 0, 0});
    vecs.push_back('{1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1, 0, 0});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h0000_000A, 32'h1111_1111, 32'h0000_0000, 1'b1, 1, 0, 0});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h0000_001E, 32'hAAAA_BEEF, 32'h0000_0000, 1'b0, 3, 1, 1});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'hFFFF_FFDC, 32'h0000_0000, 32'hBEEF_0000, 1'b0, 2, 1, 0});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h0000_0030, 32'h0000_0080, 32'h0000_0000, 1'b0, 3, 1, 1});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0000_0030, 32'h0000_0000, 32'hFFFF_FF80, 1'b0, 2, 1, 0});
    vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h0000_0009, 32'h0000_0000, 32'h0000_0000, 1'b1, 1, 0, 0});

    // Reset held for two cycles.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst req_ready", 32'(bus.req_ready), 32'd0);
      check("rst mem_we", 32'(bus.mem_we), 32'd0);
      check("rst mem_re", 32'(bus.mem_re), 32'd0);
    end
    check("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst rsp_misaligned", 32'(bus.rsp_misaligned), 32'd0);
    check("rst mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst mem_wdata", bus.mem_wdata, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst req_ready", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      run(vecs[i], i);
      if (i == 2) check("ram2 after byte store", ram[2], 32'hDEAD_5AEF);
    end
    check("ram7 after half store", ram[7], 32'hBEEF_0000);
    check("ram12 after byte store", ram[12], 32'h0000_0080);

    // Reset landing in the WRITE cycle of a byte store must abort the commit.
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b1;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0000_0008;
    bus.req_wdata    = 32'h0000_0077;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("abort rmw mem_re", 32'(bus.mem_re), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort mem_we", 32'(bus.mem_we), 32'd0);
    check("abort rsp_valid_in_rst", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    begin
      int seen = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (bus.rsp_valid || bus.mem_we || bus.mem_re) seen++;
      end
      check("abort no_activity", 32'(seen), 32'd0);
    end
    check("abort req_ready", 32'(bus.req_ready), 32'd1);
    check("abort ram2 unchanged", ram[2], 32'hDEAD_5AEF);

    // Unit still functional after the aborted transaction.
    begin
      vec_t v;
      v = '{1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0, 32'hDEAD_5AEF, 1'b0, 2, 1, 0};
      run(v, 99);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

endmodule
